// File: rtl/seq_divider32.sv
// Multi-cycle 32-bit restoring divider for MIPS DIV/DIVU: quotient to lo, remainder to hi.
// Fixed 33-edge latency from start acceptance to the done pulse, divide-by-zero included.

module seq_divider32_sub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_cout
);
  // a - b as a + ~b + cin; cout=1 means no borrow when cin=1
  logic [WIDTH:0] w_sum;

  assign w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + (WIDTH+1)'(i_cin);
  assign o_diff = w_sum[WIDTH-1:0];
  assign o_cout = w_sum[WIDTH];
endmodule

module seq_divider32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_dvd;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_p;
  logic [WIDTH-1:0] w_diff;
  logic             w_cout;
  logic             w_ok;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;
  logic             w_accept;

  // Operand magnitudes; |0x80000000| stays 0x80000000 as an unsigned value
  assign w_a_neg = is_signed & dividend[WIDTH-1];
  assign w_b_neg = is_signed & divisor[WIDTH-1];
  assign w_abs_a = w_a_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign w_abs_b = w_b_neg ? (~divisor + WIDTH'(1)) : divisor;

  // A start coinciding with done is dropped; the next one is taken a cycle later
  assign w_accept = (r_state == S_IDLE) & start & ~r_done;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor
  assign w_p = {r_r, r_q[WIDTH-1]};

  seq_divider32_sub #(
    .WIDTH (WIDTH)
  ) u_sub (
    .i_a    (w_p[WIDTH-1:0]),
    .i_b    (r_d),
    .i_cin  (1'b1),
    .o_diff (w_diff),
    .o_cout (w_cout)
  );

  assign w_ok     = w_p[WIDTH] | w_cout;
  assign w_r_next = w_ok ? w_diff : w_p[WIDTH-1:0];
  assign w_q_next = {r_q[WIDTH-2:0], w_ok};

  // Sign correction for truncating division; remainder follows the dividend sign
  assign w_lo_fix = r_dz ? '1    : (r_neg_q ? (~r_q + WIDTH'(1)) : r_q);
  assign w_hi_fix = r_dz ? r_dvd : (r_neg_r ? (~r_r + WIDTH'(1)) : r_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_d        <= '0;
      r_dvd      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_q     <= w_abs_a;
            r_r     <= '0;
            r_d     <= w_abs_b;
            r_dvd   <= dividend;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= (divisor == '0);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_q <= w_q_next;
          r_r <= w_r_next;
          if (r_cnt == LAST_CNT) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          r_lo       <= w_lo_fix;
          r_hi       <= w_hi_fix;
          r_div_zero <= r_dz;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign lo       = r_lo;
  assign hi       = r_hi;

endmodule
